// File: rtl/gpio_port_pkg.sv
// Shared constants for the GPIO peripheral: register indices, address
// field layout and the lane-count ceiling.
package gpio_port_pkg;

  localparam int ADDR_W     = 5;
  localparam int REG_IDX_W  = 3;
  localparam int LANE_W     = 2;
  localparam int MAX_NBYTES = 4;

  typedef enum logic [REG_IDX_W-1:0] {
    REG_OUT  = 3'd0,
    REG_DIR  = 3'd1,
    REG_IN   = 3'd2,
    REG_IEN  = 3'd3,
    REG_EPOL = 3'd4,
    REG_EANY = 3'd5,
    REG_IFLG = 3'd6,
    REG_RSVD = 3'd7
  } reg_idx_e;

  // Register index lives in the upper address bits.
  function automatic reg_idx_e reg_index(input logic [ADDR_W-1:0] a);
    return reg_idx_e'(a[ADDR_W-1:LANE_W]);
  endfunction

  // Byte lane lives in the lower address bits.
  function automatic logic [LANE_W-1:0] lane_index(input logic [ADDR_W-1:0] a);
    return a[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser for a pin vector plus a previous-value flop, giving
// the synchronised level and single-cycle rise/fall strobes per bit.
module gpio_sync_edge
  import gpio_port_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  // Stage 0 samples the asynchronous pins; the last stage is the safe level.
  logic [SYNC_STAGES-1:0][W-1:0] chain_reg;
  logic [W-1:0]                  prev_reg;

  // Shift the pins through the synchroniser and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_reg <= '0;
      prev_reg  <= '0;
    end else begin
      chain_reg <= {chain_reg[SYNC_STAGES-2:0], d};
      prev_reg  <= chain_reg[SYNC_STAGES-1];
    end
  end

  assign s = chain_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign rise[gi] =  s[gi] & ~prev_reg[gi];
      assign fall[gi] = ~s[gi] &  prev_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/gpio_port.sv
// Bus-attached GPIO peripheral: byte-lane register file, per-bit direction,
// synchronised inputs, edge-detect flags (W1C) and a level irq.
module gpio_port
  import gpio_port_pkg::*;
#(
  parameter  int NBYTES      = 1,
  parameter  int SYNC_STAGES = 2,
  localparam int W           = 8 * NBYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              irq,
  input  logic [W-1:0]      gpio_i,
  output logic [W-1:0]      gpio_o,
  output logic [W-1:0]      gpio_oe
);

  // The arming counter stops at SYNC_STAGES+1, by which point the
  // synchroniser and previous-value flop hold real pin data.
  localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [W-1:0] out_reg,  out_next;
  logic [W-1:0] dir_reg,  dir_next;
  logic [W-1:0] ien_reg,  ien_next;
  logic [W-1:0] epol_reg, epol_next;
  logic [W-1:0] eany_reg, eany_next;
  logic [W-1:0] iflg_reg, iflg_next;
  logic [7:0]   dout_reg, dout_next;
  logic         irq_reg,  irq_next;
  logic [ARM_W-1:0] arm_cnt_reg, arm_cnt_next;

  logic         armed;
  logic         wr_en;
  logic         rd_en;
  reg_idx_e     reg_idx;
  logic [LANE_W-1:0] lane_idx;
  logic [W-1:0] lane_mask;
  logic [W-1:0] din_rep;
  logic [W-1:0] w1c;
  logic [W-1:0] sync_s, sync_rise, sync_fall, edge_evt;
  logic [W-1:0] rd_word;
  logic [MAX_NBYTES-1:0][7:0] rd_lane;

  assign wr_en    = cs & we;
  assign rd_en    = cs & ~we;
  assign reg_idx  = reg_index(addr);
  assign lane_idx = lane_index(addr);

  gpio_sync_edge #(
    .W           (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gpio_i),
    .s     (sync_s),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  // Lanes beyond NBYTES have no mask bits (writes vanish) and read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_NBYTES; gi++) begin : g_lane
      if (gi < NBYTES) begin : g_present
        assign lane_mask[8*gi +: 8] = {8{lane_idx == LANE_W'(gi)}};
        assign din_rep[8*gi +: 8]   = din;
        assign rd_lane[gi]          = rd_word[8*gi +: 8];
      end else begin : g_absent
        assign rd_lane[gi] = 8'h00;
      end
    end
  endgenerate

  // EANY takes priority over EPOL when choosing which edges count.
  assign edge_evt = (eany_reg & (sync_rise | sync_fall)) |
                    (~eany_reg & ((epol_reg & sync_rise) | (~epol_reg & sync_fall)));

  assign armed = (arm_cnt_reg == ARM_DONE);

  // Byte-lane writes into the register file; IFLG writes become a clear mask.
  always_comb begin
    out_next  = out_reg;
    dir_next  = dir_reg;
    ien_next  = ien_reg;
    epol_next = epol_reg;
    eany_next = eany_reg;
    w1c       = '0;
    if (wr_en) begin
      case (reg_idx)
        REG_OUT:  out_next  = (out_reg  & ~lane_mask) | (din_rep & lane_mask);
        REG_DIR:  dir_next  = (dir_reg  & ~lane_mask) | (din_rep & lane_mask);
        REG_IEN:  ien_next  = (ien_reg  & ~lane_mask) | (din_rep & lane_mask);
        REG_EPOL: epol_next = (epol_reg & ~lane_mask) | (din_rep & lane_mask);
        REG_EANY: eany_next = (eany_reg & ~lane_mask) | (din_rep & lane_mask);
        REG_IFLG: w1c       = din_rep & lane_mask;
        default:  ;
      endcase
    end
  end

  // Flags: a new event beats a simultaneous clear; events are ignored until armed.
  always_comb begin
    iflg_next    = (iflg_reg & ~w1c) | (armed ? edge_evt : '0);
    irq_next     = |(iflg_reg & ien_reg);
    arm_cnt_next = armed ? arm_cnt_reg : arm_cnt_reg + 1'b1;
  end

  // Read mux: select the register, then the byte lane; dout holds otherwise.
  always_comb begin
    rd_word = '0;
    case (reg_idx)
      REG_OUT:  rd_word = out_reg;
      REG_DIR:  rd_word = dir_reg;
      REG_IN:   rd_word = sync_s;
      REG_IEN:  rd_word = ien_reg;
      REG_EPOL: rd_word = epol_reg;
      REG_EANY: rd_word = eany_reg;
      REG_IFLG: rd_word = iflg_reg;
      default:  rd_word = '0;
    endcase
    dout_next = rd_en ? rd_lane[lane_idx] : dout_reg;
  end

  // State register for the whole peripheral.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg     <= '0;
      dir_reg     <= '0;
      ien_reg     <= '0;
      epol_reg    <= '0;
      eany_reg    <= '0;
      iflg_reg    <= '0;
      dout_reg    <= '0;
      irq_reg     <= 1'b0;
      arm_cnt_reg <= '0;
    end else begin
      out_reg     <= out_next;
      dir_reg     <= dir_next;
      ien_reg     <= ien_next;
      epol_reg    <= epol_next;
      eany_reg    <= eany_next;
      iflg_reg    <= iflg_next;
      dout_reg    <= dout_next;
      irq_reg     <= irq_next;
      arm_cnt_reg <= arm_cnt_next;
    end
  end

  assign gpio_o  = out_reg;
  assign gpio_oe = dir_reg;
  assign dout    = dout_reg;
  assign irq     = irq_reg;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port with NBYTES=2, SYNC_STAGES=2.
module tb_gpio_port;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  localparam logic [2:0] R_OUT  = 3'd0;
  localparam logic [2:0] R_DIR  = 3'd1;
  localparam logic [2:0] R_IN   = 3'd2;
  localparam logic [2:0] R_IEN  = 3'd3;
  localparam logic [2:0] R_EPOL = 3'd4;
  localparam logic [2:0] R_EANY = 3'd5;
  localparam logic [2:0] R_IFLG = 3'd6;

  logic         clk = 1'b0;
  logic         reset;
  logic         cs;
  logic         we;
  logic [4:0]   addr;
  logic [7:0]   din;
  logic [7:0]   dout;
  logic         irq;
  logic [W-1:0] gpio_i;
  logic [W-1:0] gpio_o;
  logic [W-1:0] gpio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_port #(
    .NBYTES      (NB),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .irq     (irq),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] idx, input logic [1:0] lane, input logic [7:0] data);
    cs = 1'b1; we = 1'b1; addr = {idx, lane}; din = data;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, input logic [1:0] lane, output logic [7:0] data);
    cs = 1'b1; we = 1'b0; addr = {idx, lane};
    tick();
    cs = 1'b0;
    data = dout;
  endtask

  initial begin
    logic [7:0] r;

    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0; gpio_i = '0;
    #1;
    ticks(4);
    reset = 1'b0;

    // Reset defaults
    check_val("rst_oe",  32'(gpio_oe), 32'h0000);
    check_val("rst_o",   32'(gpio_o),  32'h0000);
    check_val("rst_irq", 32'(irq),     32'h0);
    for (int ri = 0; ri < 8; ri++) begin
      for (int li = 0; li < 2; li++) begin
        rd(3'(ri), 2'(li), r);
        check_val($sformatf("rst_reg%0d_lane%0d", ri, li), 32'(r), 32'h00);
      end
    end

    // Output path
    wr(R_DIR, 2'd0, 8'hF0);
    check_val("dir_oe", 32'(gpio_oe), 32'h00F0);
    wr(R_OUT, 2'd0, 8'hA5);
    check_val("out_l0", 32'(gpio_o), 32'h00A5);
    wr(R_OUT, 2'd1, 8'h3C);
    check_val("out_l1", 32'(gpio_o), 32'h3CA5);
    rd(R_OUT, 2'd1, r);
    check_val("out_l1_rb", 32'(r), 32'h3C);
    rd(R_DIR, 2'd0, r);
    check_val("dir_l0_rb", 32'(r), 32'hF0);
    wr(R_OUT, 2'd2, 8'h55);
    check_val("out_l2_ign", 32'(gpio_o), 32'h3CA5);
    rd(R_OUT, 2'd2, r);
    check_val("out_l2_rd", 32'(r), 32'h00);

    // Synchroniser latency on bit 9
    gpio_i[9] = 1'b1;
    rd(R_IN, 2'd1, r);
    check_val("in_lat1", 32'(r), 32'h00);
    rd(R_IN, 2'd1, r);
    check_val("in_lat2", 32'(r), 32'h00);
    rd(R_IN, 2'd1, r);
    check_val("in_lat3", 32'(r), 32'h02);
    // dout holds while cs is low
    tick();
    check_val("dout_hold", 32'(dout), 32'h02);

    // Rising-edge interrupt on bit 0
    wr(R_IEN, 2'd0, 8'h01);
    wr(R_EPOL, 2'd0, 8'h01);
    gpio_i[0] = 1'b1;
    ticks(2);
    rd(R_IFLG, 2'd0, r);
    check_val("rise_flg_early", 32'(r), 32'h00);
    check_val("rise_irq_early", 32'(irq), 32'h0);
    rd(R_IFLG, 2'd0, r);
    check_val("rise_flg", 32'(r), 32'h01);
    check_val("rise_irq", 32'(irq), 32'h1);
    wr(R_IFLG, 2'd0, 8'h01);
    check_val("clr_irq_lag", 32'(irq), 32'h1);
    tick();
    check_val("clr_irq", 32'(irq), 32'h0);
    rd(R_IFLG, 2'd0, r);
    check_val("clr_flg", 32'(r), 32'h00);

    // Falling-edge mode
    wr(R_EPOL, 2'd0, 8'h00);
    gpio_i[0] = 1'b0;
    ticks(4);
    rd(R_IFLG, 2'd0, r);
    check_val("fall_flg", 32'(r), 32'h01);
    check_val("fall_irq", 32'(irq), 32'h1);
    wr(R_IFLG, 2'd0, 8'h01);
    gpio_i[0] = 1'b1;
    ticks(4);
    rd(R_IFLG, 2'd0, r);
    check_val("fall_rise_noflg", 32'(r), 32'h00);
    check_val("fall_rise_noirq", 32'(irq), 32'h0);

    // Any-edge mode overrides EPOL
    wr(R_EANY, 2'd0, 8'h01);
    gpio_i[0] = 1'b0;
    ticks(4);
    rd(R_IFLG, 2'd0, r);
    check_val("any_fall_flg", 32'(r), 32'h01);
    wr(R_IFLG, 2'd0, 8'h01);
    gpio_i[0] = 1'b1;
    ticks(4);
    rd(R_IFLG, 2'd0, r);
    check_val("any_rise_flg", 32'(r), 32'h01);
    wr(R_IFLG, 2'd0, 8'h01);

    // Flag sets without enable, irq stays low
    wr(R_IEN, 2'd0, 8'h00);
    gpio_i[0] = 1'b0;
    ticks(4);
    rd(R_IFLG, 2'd0, r);
    check_val("noen_flg", 32'(r), 32'h01);
    tick();
    check_val("noen_irq", 32'(irq), 32'h0);
    wr(R_IFLG, 2'd0, 8'h01);
    rd(R_IFLG, 2'd0, r);
    check_val("noen_clr", 32'(r), 32'h00);

    // W1C colliding with a new edge: set wins
    wr(R_IEN, 2'd0, 8'h01);
    gpio_i[0] = 1'b1;
    ticks(4);
    gpio_i[0] = 1'b0;
    ticks(2);
    wr(R_IFLG, 2'd0, 8'h01);   // lands on the same edge that records the fall
    rd(R_IFLG, 2'd0, r);
    check_val("w1c_vs_set", 32'(r), 32'h01);
    check_val("w1c_vs_set_irq", 32'(irq), 32'h1);

    // Reset with a flag pending and irq high
    gpio_i = '1;
    reset = 1'b1;
    tick();
    check_val("mid_rst_irq",  32'(irq),     32'h0);
    check_val("mid_rst_dout", 32'(dout),    32'h00);
    check_val("mid_rst_o",    32'(gpio_o),  32'h0000);
    check_val("mid_rst_oe",   32'(gpio_oe), 32'h0000);
    ticks(3);
    reset = 1'b0;

    // Arming window: pins high through reset, any-edge enabled immediately
    wr(R_EANY, 2'd0, 8'hFF);
    wr(R_EANY, 2'd1, 8'hFF);
    rd(R_IN, 2'd0, r);
    check_val("arm_in_l0", 32'(r), 32'hFF);
    ticks(4);
    rd(R_IFLG, 2'd0, r);
    check_val("arm_flg_l0", 32'(r), 32'h00);
    rd(R_IFLG, 2'd1, r);
    check_val("arm_flg_l1", 32'(r), 32'h00);
    check_val("arm_irq", 32'(irq), 32'h0);
    rd(R_IN, 2'd1, r);
    check_val("arm_in_l1", 32'(r), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
